// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy and a wrap pulse.
// bin and gray are updated on the same edge, so gray always encodes bin.
module gray_counter #(
  parameter int            N         = 4,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] bin,
  output logic [N-1:0] gray,
  output logic         wrap
);

  localparam logic [N-1:0] ONE        = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [N-1:0] bin_next;
  logic [N-1:0] gray_next;
  logic         wrap_next;

  // Priority load > en > hold; reset is applied in the register stage.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        bin_next  = bin + ONE;
        wrap_next = &bin;
      end else begin
        bin_next  = bin - ONE;
        wrap_next = ~|bin;
      end
    end
  end

  // Gray is derived from the next binary value so both registers move together.
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all three registers sampling pre-edge values.
    if (reset) begin
      bin  <= RESET_VAL;
      gray <= RESET_GRAY;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed vector table plus hand sequences and a randomised reference-model run
// for gray_counter (N = 4, with a second RESET_VAL = 3 instance).
module tb_gray_counter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset, en, up, load;
  logic [N-1:0] load_bin;
  logic [N-1:0] bin, gray, bin3, gray3;
  logic         wrap, wrap3;

  int checks = 0;
  int errors = 0;

  gray_counter #(.N(N), .RESET_VAL(4'd0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap)
  );

  gray_counter #(.N(N), .RESET_VAL(4'd3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .bin(bin3), .gray(gray3), .wrap(wrap3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         reset, en, up, load;
    logic [N-1:0] load_bin;
    logic [N-1:0] exp_bin, exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [N-1:0] lb, input logic [N-1:0] b,
                     input logic [N-1:0] g, input logic w);
    vec_t v;
    v.reset = r; v.en = e; v.up = u; v.load = l; v.load_bin = lb;
    v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [N-1:0] lb);
    reset = r; en = e; up = u; load = l; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] gray_decode(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Hand-computed Gray codes for 0..F.
  logic [N-1:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    logic [N-1:0] m_bin, m_gray, prev_gray;
    logic         m_wrap, was_step;

    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;

    // Test 1: reset then 16 up steps; wrap only on the 16th; then pulse clears.
    add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 1; i <= 16; i++)
      add(0, 1, 1, 0, 4'h0, 4'(i), gtab[i % 16], (i == 16));
    add(0, 0, 1, 0, 4'h5, 4'h0, 4'h0, 0);
    // Test 2: down from zero wraps to F, then E.
    add(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1);
    add(0, 1, 0, 0, 4'h0, 4'hE, 4'h9, 0);
    // Test 3: load beats en; then one up step.
    add(0, 1, 1, 1, 4'hA, 4'hA, 4'hF, 0);
    add(0, 1, 1, 0, 4'h3, 4'hB, 4'hE, 0);
    // Load from F after up-to-F: no wrap despite en/up.
    add(0, 1, 1, 1, 4'hF, 4'hF, 4'h8, 0);
    add(0, 1, 1, 1, 4'h0, 4'h0, 4'h0, 0);
    // Test 4: up to 5, hold 3 cycles, reset during en, reset overrides load.
    add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 4'h0, 4'(i), gtab[i], 0);
    for (int i = 0; i < 3; i++)  add(0, 0, i[0], 0, 4'h9, 4'h5, 4'h7, 0);
    add(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    add(1, 1, 0, 1, 4'h9, 4'h0, 4'h0, 0);
    add(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0);

    // Test 5 (hand sequence): RESET_VAL = 3 instance.
    step(1, 0, 0, 0, 4'h0);
    check("rv3_reset_bin", 32'(bin3), 32'h3);
    check("rv3_reset_gray", 32'(gray3), 32'h2);
    check("rv3_reset_wrap", 32'(wrap3), 32'h0);
    step(0, 1, 1, 0, 4'h0);
    check("rv3_up_bin", 32'(bin3), 32'h4);
    check("rv3_up_gray", 32'(gray3), 32'h6);

    // Directed table.
    foreach (vecs[i]) begin
      step(vecs[i].reset, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_bin);
      check($sformatf("vec%0d_bin", i),  32'(bin),  32'(vecs[i].exp_bin));
      check($sformatf("vec%0d_gray", i), 32'(gray), 32'(vecs[i].exp_gray));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end

    // Test 6: random stimulus against an independent reference model.
    step(1, 0, 0, 0, 4'h0);
    m_bin = 4'h0;
    prev_gray = gray;
    for (int c = 0; c < 10000; c++) begin
      logic r, e, u, l;
      logic [N-1:0] lb;
      r  = ($urandom_range(0, 255) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) != 0;
      l  = ($urandom_range(0, 15) == 0);
      lb = 4'($urandom_range(0, 15));
      m_wrap = 1'b0;
      was_step = 1'b0;
      if (r) m_bin = 4'h0;
      else if (l) m_bin = lb;
      else if (e) begin
        was_step = 1'b1;
        if (u) begin m_wrap = (m_bin == 4'hF); m_bin = m_bin + 4'h1; end
        else   begin m_wrap = (m_bin == 4'h0); m_bin = m_bin - 4'h1; end
      end
      m_gray = gtab[m_bin];
      step(r, e, u, l, lb);
      check($sformatf("rnd%0d_bin", c),    32'(bin),  32'(m_bin));
      check($sformatf("rnd%0d_gray", c),   32'(gray), 32'(m_gray));
      check($sformatf("rnd%0d_decode", c), 32'(gray_decode(gray)), 32'(m_bin));
      check($sformatf("rnd%0d_wrap", c),   32'(wrap), 32'(m_wrap));
      if (was_step)
        check($sformatf("rnd%0d_onebit", c), 32'($countones(gray ^ prev_gray)), 32'd1);
      prev_gray = gray;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
